data_memory_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-ported `DataMemoryManager` between two requesters (port 0: CPU load/store unit, port 1: DMA/peripheral engine). It sits directly in front of `DataMemoryManager` and drives its `address_i`/`data_i`/`wren_i`. It tracks the fixed memory read latency with a tag pipeline and routes `data_o` back to the requester that issued each read. It also keeps saturating per-port grant and contention counters for performance debug.

---
 rtl/data_memory_arbiter.sv | 112 +++++++++++
 tb/tb_data_memory_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port round-robin arbiter in front of DataMemoryManager
//
// Shares one single-ported data memory between port 0 (CPU load/store) and
// port 1 (DMA/peripheral). Grants are combinational; read data is routed back
// through a tag pipeline matched to the fixed memory read latency RD_LAT.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   reqN_i, weN_i            request valid and write enable per port
//   addrN_i, wdataN_i        request payload per port
//   gntN_o                   combinational grant per port
//   rvalidN_o, rdataN_o      read response strobe and data per port
//   mem_address_o/data_o     address / write data to the memory
//   mem_wren_o               write enable to the memory
//   mem_data_i               read data from the memory
//   gnt_cnt0_o, gnt_cnt1_o   saturating accepted-transaction counters
//   conflict_cnt_o           saturating count of cycles with both requests
module data_memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [15:0]       gnt_cnt0_o,
  output logic [15:0]       gnt_cnt1_o,
  output logic [15:0]       conflict_cnt_o
);

  // prio = port that wins the next cycle in which both ports request
  logic              prio;
  logic [RD_LAT-1:0] tag_valid;
  logic [RD_LAT-1:0] tag_port;
  logic              rd_push;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!RST) begin
      if (req0_i && (!req1_i || !prio)) begin
        gnt0_o = 1'b1;
      end else if (req1_i) begin
        gnt1_o = 1'b1;
      end
    end
  end

  // With no grant the memory sees port 0's payload; wren stays qualified.
  assign mem_address_o = gnt1_o ? addr1_i : addr0_i;
  assign mem_data_o    = gnt1_o ? wdata1_i : wdata0_i;
  assign mem_wren_o    = (gnt0_o & we0_i) | (gnt1_o & we1_i);
  assign rd_push       = (gnt0_o & ~we0_i) | (gnt1_o & ~we1_i);

  // The last tag stage lines up with the cycle mem_data_i carries the read.
  assign rvalid0_o = tag_valid[RD_LAT-1] & ~tag_port[RD_LAT-1];
  assign rvalid1_o = tag_valid[RD_LAT-1] &  tag_port[RD_LAT-1];
  assign rdata0_o  = mem_data_i;
  assign rdata1_o  = mem_data_i;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio           <= 1'b0;
      tag_valid      <= '0;
      tag_port       <= '0;
      gnt_cnt0_o     <= 16'h0000;
      gnt_cnt1_o     <= 16'h0000;
      conflict_cnt_o <= 16'h0000;
    end else begin
      if (gnt0_o) begin
        prio <= 1'b1;
      end else if (gnt1_o) begin
        prio <= 1'b0;
      end

      tag_valid[0] <= rd_push;
      tag_port[0]  <= gnt1_o;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_port[i]  <= tag_port[i-1];
      end

      if (gnt0_o && gnt_cnt0_o != 16'hFFFF) begin
        gnt_cnt0_o <= gnt_cnt0_o + 16'd1;
      end
      if (gnt1_o && gnt_cnt1_o != 16'hFFFF) begin
        gnt_cnt1_o <= gnt_cnt1_o + 16'd1;
      end
      if (req0_i && req1_i && conflict_cnt_o != 16'hFFFF) begin
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking bench for data_memory_arbiter (RD_LAT 2 and 3)
module tb_data_memory_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  logic        gnt0, gnt1, rv0, rv1, mwren;
  logic [31:0] rd0, rd1, maddr, mdo, mdi;
  logic [15:0] c0, c1, cf;

  logic        g30, g31, r3v0, r3v1, mwren3;
  logic [31:0] r3d0, r3d1, maddr3, mdo3, mdi3;
  logic [15:0] c30, c31, c3f;

  data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut (
    .CLK(clk), .RST(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rv0), .rvalid1_o(rv1),
    .rdata0_o(rd0), .rdata1_o(rd1),
    .mem_address_o(maddr), .mem_data_o(mdo), .mem_wren_o(mwren), .mem_data_i(mdi),
    .gnt_cnt0_o(c0), .gnt_cnt1_o(c1), .conflict_cnt_o(cf)
  );

  data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
    .CLK(clk), .RST(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(g30), .gnt1_o(g31), .rvalid0_o(r3v0), .rvalid1_o(r3v1),
    .rdata0_o(r3d0), .rdata1_o(r3d1),
    .mem_address_o(maddr3), .mem_data_o(mdo3), .mem_wren_o(mwren3), .mem_data_i(mdi3),
    .gnt_cnt0_o(c30), .gnt_cnt1_o(c31), .conflict_cnt_o(c3f)
  );

  // Memory stand-in: 16 words, fixed read latency of 2 and 3 cycles.
  logic [31:0] mem [16];
  logic [31:0] p2 [2];
  logic [31:0] p3 [3];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (mwren) mem[maddr[3:0]] <= mdo;
    p2[0] <= mem[maddr[3:0]];
    p2[1] <= p2[0];
    p3[0] <= mem[maddr3[3:0]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mdi  = p2[1];
  assign mdi3 = p3[2];

  // Reference model state: shadow memory, issue-slot table, counters.
  logic [31:0] shadow [16];
  logic        sl_v [8];
  int          sl_c [8];
  logic        sl_p [8];
  logic [31:0] sl_d [8];
  logic        m_prio;
  logic [15:0] m_c0, m_c1, m_cf;
  int          cyc;
  int          total, bad;

  logic [1:0]   e_g, e_rv2, e_rv3, s_gnt, s_rv2, s_rv3;
  logic         e_wren;
  logic [31:0]  e_addr, e_wd, e_rd2, e_rd3, s_rd2, s_rd3;
  logic [15:0]  e_c0, e_c1, e_cf, s_c0, s_c1, s_cf;
  logic [134:0] obs, expv;

  task automatic due(input int lat, output logic [1:0] v, output logic [31:0] d);
    int s;
    s = (cyc - lat) & 7;
    v = 2'b00;
    d = 32'h0;
    if (sl_v[s] && sl_c[s] == cyc - lat) begin
      v = sl_p[s] ? 2'b10 : 2'b01;
      d = sl_d[s];
    end
  endtask

  // Advance one cycle: sample outputs just after the falling edge, form the
  // model's expectations, then retire the cycle's effects at the rising edge.
  task automatic tick();
    int k;
    #1;
    if (rst) begin
      m_prio = 1'b0; m_c0 = 16'h0; m_c1 = 16'h0; m_cf = 16'h0;
      for (int i = 0; i < 8; i++) sl_v[i] = 1'b0;
    end
    e_g = 2'b00;
    if (!rst) begin
      if (req0 && req1) e_g = m_prio ? 2'b10 : 2'b01;
      else if (req0)    e_g = 2'b01;
      else if (req1)    e_g = 2'b10;
    end
    e_wren = (e_g[0] && we0) || (e_g[1] && we1);
    e_addr = e_g[1] ? addr1 : addr0;
    e_wd   = e_g[1] ? wdata1 : wdata0;
    due(2, e_rv2, e_rd2);
    due(3, e_rv3, e_rd3);
    e_c0 = m_c0; e_c1 = m_c1; e_cf = m_cf;

    s_gnt = {gnt1, gnt0};
    s_rv2 = {rv1, rv0};
    s_rv3 = {r3v1, r3v0};
    s_rd2 = rv0 ? rd0 : (rv1 ? rd1 : 32'h0);
    s_rd3 = r3v0 ? r3d0 : (r3v1 ? r3d1 : 32'h0);
    s_c0 = c0; s_c1 = c1; s_cf = cf;
    obs  = {s_gnt, s_rv2, s_rv3, mwren, maddr, mdo, s_rd2, s_rd3};
    expv = {e_g, e_rv2, e_rv3, e_wren, e_addr, e_wd, e_rd2, e_rd3};

    @(posedge clk);
    if (!rst) begin
      if (req0 && req1 && m_cf != 16'hFFFF) m_cf = m_cf + 16'd1;
      if (e_g != 2'b00) begin
        if (e_g[0] && m_c0 != 16'hFFFF) m_c0 = m_c0 + 16'd1;
        if (e_g[1] && m_c1 != 16'hFFFF) m_c1 = m_c1 + 16'd1;
        m_prio = e_g[0];
        if (e_wren) begin
          shadow[e_addr[3:0]] = e_wd;
        end else begin
          k = cyc & 7;
          sl_v[k] = 1'b1;
          sl_c[k] = cyc;
          sl_p[k] = e_g[1];
          sl_d[k] = shadow[e_addr[3:0]];
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; idle(); tick();
    rst = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 32'h11; addr1 = 32'h22; wdata0 = 32'hA0; wdata1 = 32'hB0;
    tick();
    total++;
    if (obs !== expv) begin
      bad++; $display("FAIL reset_outputs cyc=%0d got=%h want=%h", cyc, obs, expv);
    end
    total++;
    if ({s_gnt, s_rv2, s_rv3} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=000000", {s_gnt, s_rv2, s_rv3});
    end
    total++;
    if ({s_c0, s_c1, s_cf} !== 48'h0) begin
      bad++; $display("FAIL reset_counters got=%h want=0", {s_c0, s_c1, s_cf});
    end
    rst = 1'b0; idle(); tick();
  endtask

  task automatic test_write_read();
    int n;
    n = 0;
    pulse_reset();
    for (int a = 0; a < 30; a++) begin
      idle();
      if (a < 20) begin
        req0 = 1'b1; we0 = (a < 10); addr0 = a % 10; wdata0 = 100 + (a % 10);
      end
      tick();
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL write_read cyc=%0d got=%h want=%h", cyc, obs, expv);
      end
      if (s_rv2 != 2'b00) begin
        total++;
        if (s_rv2 !== 2'b01 || s_rd2 !== 100 + n || a !== 12 + n) begin
          bad++; $display("FAIL write_read_data step=%0d got=%b/%0d want=01/%0d", a, s_rv2, s_rd2, 100 + n);
        end
        n++;
      end
    end
    total++;
    if (n !== 10) begin
      bad++; $display("FAIL write_read_count got=%0d want=10", n);
    end
    total++;
    if (s_c0 !== 16'd20 || s_c1 !== 16'd0) begin
      bad++; $display("FAIL write_read_gnt_cnt got=%0d/%0d want=20/0", s_c0, s_c1);
    end
  endtask

  task automatic test_alternate();
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      idle();
      if (i < 12) begin
        req0 = 1'b1; addr0 = 32'd5; req1 = 1'b1; addr1 = 32'd6;
      end
      tick();
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL alternate cyc=%0d got=%h want=%h", cyc, obs, expv);
      end
      if (i < 12) begin
        total++;
        if (s_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL alternate_order i=%0d got=%b", i, s_gnt);
        end
      end
    end
    total++;
    if (s_cf !== 16'd12 || s_c0 !== 16'd6 || s_c1 !== 16'd6) begin
      bad++; $display("FAIL alternate_counts got=%0d/%0d/%0d want=12/6/6", s_cf, s_c0, s_c1);
    end
  endtask

  task automatic test_raw();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) begin req1 = 1'b1; we1 = 1'b1; addr1 = 32'd7; wdata1 = 32'hDEAD; end
      if (i == 1) begin req0 = 1'b1; addr0 = 32'd7; end
      tick();
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL raw cyc=%0d got=%h want=%h", cyc, obs, expv);
      end
      total++;
      if ((i == 3) ? (s_rv2 !== 2'b01 || s_rd2 !== 32'hDEAD) : (s_rv2 !== 2'b00)) begin
        bad++; $display("FAIL raw_resp i=%0d got=%b/%h", i, s_rv2, s_rd2);
      end
      total++;
      if ((i == 4) ? (s_rv3 !== 2'b01 || s_rd3 !== 32'hDEAD) : (s_rv3 !== 2'b00)) begin
        bad++; $display("FAIL lat3_resp i=%0d got=%b/%h", i, s_rv3, s_rd3);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      idle();
      rst = (i == 1);
      if (i < 2) begin req0 = 1'b1; addr0 = 32'd3 + i; end
      if (i == 4) begin req0 = 1'b1; req1 = 1'b1; addr0 = 32'd1; addr1 = 32'd2; end
      tick();
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, obs, expv);
      end
      if (i == 2 || i == 3) begin
        total++;
        if ({s_rv2, s_rv3, s_c0, s_c1, s_cf} !== 52'h0) begin
          bad++; $display("FAIL reset_mid_clear i=%0d got=%b%b %0d/%0d/%0d", i, s_rv2, s_rv3, s_c0, s_c1, s_cf);
        end
      end
    end
    rst = 1'b0;
    total++;
    if (s_gnt !== 2'b01) begin
      bad++; $display("FAIL reset_mid_first_grant got=%b want=01", s_gnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(63, 0) == 0);
      req0   = ($urandom_range(3, 0) != 0);
      req1   = ($urandom_range(3, 0) != 0);
      we0    = $urandom_range(1, 0);
      we1    = $urandom_range(1, 0);
      addr0  = $urandom;
      addr1  = $urandom;
      wdata0 = $urandom;
      wdata1 = $urandom;
      tick();
      total++;
      if (obs !== expv || {s_c0, s_c1, s_cf} !== {e_c0, e_c1, e_cf}) begin
        bad++; $display("FAIL random cyc=%0d got=%h %h want=%h %h", cyc, obs, {s_c0, s_c1, s_cf}, expv, {e_c0, e_c1, e_cf});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_saturate();
    pulse_reset();
    for (int i = 0; i < 65541; i++) begin
      idle();
      if (i < 65540) begin
        req0 = 1'b1; req1 = 1'b1;
        we0 = $urandom_range(1, 0); we1 = $urandom_range(1, 0);
        addr0 = $urandom_range(15, 0); addr1 = $urandom_range(15, 0);
        wdata0 = $urandom; wdata1 = $urandom;
      end
      tick();
      if (obs !== expv) begin
        total++; bad++; $display("FAIL saturate cyc=%0d got=%h want=%h", cyc, obs, expv);
      end
      if (i == 65534) begin
        total++;
        if (s_cf !== 16'hFFFE) begin
          bad++; $display("FAIL saturate_pre got=%h want=fffe", s_cf);
        end
      end
    end
    total++;
    if (s_cf !== 16'hFFFF) begin
      bad++; $display("FAIL saturate_hold got=%h want=ffff", s_cf);
    end
    total++;
    if (s_c0 !== 16'd32770 || s_c1 !== 16'd32770) begin
      bad++; $display("FAIL saturate_gnt got=%0d/%0d want=32770/32770", s_c0, s_c1);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    m_prio = 1'b0; m_c0 = 16'h0; m_c1 = 16'h0; m_cf = 16'h0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin sl_v[i] = 1'b0; sl_c[i] = -100; end
    rst = 1'b1;
    idle();
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_alternate();
    test_raw();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
